// File: rtl/data_mem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus an MMIO window
// holding a GPIO output register and a compare/auto-reload timer.
module data_mem_mmio #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    localparam logic [9:0] OFF_GPIO  = 10'd0;
    localparam logic [9:0] OFF_CTRL  = 10'd1;
    localparam logic [9:0] OFF_COUNT = 10'd2;
    localparam logic [9:0] OFF_CMP   = 10'd3;
    localparam logic [9:0] OFF_STAT  = 10'd4;

    logic [31:0]   ram [DEPTH];
    logic [31:0]   gpio_reg;
    logic [2:0]    ctrl;
    logic [31:0]   count;
    logic [31:0]   cmp;
    logic          match;

    logic          ram_sel;
    logic          mmio_sel;
    logic [AW-1:0] ram_idx;
    logic [9:0]    word_off;
    logic          wr_gpio;
    logic          wr_ctrl;
    logic          wr_count;
    logic          wr_cmp;
    logic          wr_stat;
    logic          tmr_en;
    logic          tmr_reload;
    logic          tmr_irq_en;
    logic          hit;

    // Low two address bits are ignored everywhere: all accesses are whole words.
    assign ram_sel  = (DataAdr < RAM_BYTES);
    assign mmio_sel = (DataAdr[31:12] == MMIO_BASE[31:12]);
    assign ram_idx  = DataAdr[AW+1:2];
    assign word_off = DataAdr[11:2];

    assign wr_gpio  = MemWrite && mmio_sel && (word_off == OFF_GPIO);
    assign wr_ctrl  = MemWrite && mmio_sel && (word_off == OFF_CTRL);
    assign wr_count = MemWrite && mmio_sel && (word_off == OFF_COUNT);
    assign wr_cmp   = MemWrite && mmio_sel && (word_off == OFF_CMP);
    assign wr_stat  = MemWrite && mmio_sel && (word_off == OFF_STAT);

    assign tmr_en     = ctrl[0];
    assign tmr_reload = ctrl[1];
    assign tmr_irq_en = ctrl[2];
    assign hit        = (count == cmp);

    always_ff @(posedge clk) begin
        if (MemWrite && ram_sel) begin
            ram[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_reg <= '0;
            ctrl     <= '0;
            count    <= '0;
            cmp      <= 32'hFFFF_FFFF;
            match    <= 1'b0;
        end else begin
            if (wr_gpio) gpio_reg <= WriteData;
            if (wr_ctrl) ctrl     <= WriteData[2:0];
            if (wr_cmp)  cmp      <= WriteData;

            // A CPU write to COUNT beats both increment and reload.
            if (wr_count) begin
                count <= WriteData;
            end else if (tmr_en) begin
                if (hit && tmr_reload) count <= '0;
                else                   count <= count + 32'd1;
            end

            // A fresh match wins over a simultaneous W1C clear.
            if (tmr_en && hit) begin
                match <= 1'b1;
            end else if (wr_stat && WriteData[0]) begin
                match <= 1'b0;
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (ram_sel) begin
            ReadData = ram[ram_idx];
        end else if (mmio_sel) begin
            case (word_off)
                OFF_GPIO:  ReadData = gpio_reg;
                OFF_CTRL:  ReadData = {29'd0, ctrl};
                OFF_COUNT: ReadData = count;
                OFF_CMP:   ReadData = cmp;
                OFF_STAT:  ReadData = {31'd0, match};
                default:   ReadData = '0;
            endcase
        end
    end

    assign gpio_out  = gpio_reg;
    assign timer_irq = match && tmr_irq_en;

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
Data-side memory subsystem directly downstream of the single-cycle core. It consumes the core's data-port outputs (DataAdr, WriteData, MemWrite) and returns ReadData in the same cycle. It contains a word-addressed data RAM and a small memory-mapped peripheral block: a GPIO output register and a 32-bit timer with compare, auto-reload and interrupt.

Parameters:
DEPTH, 64, number of 32-bit RAM words; power of two, at least 4.
MMIO_BASE, 32'h0000_1000, 4 KB-aligned base of the peripheral window; must lie above DEPTH*4.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low.
DataAdr  input  32  byte address from the core (ALU result).
WriteData  input  32  store data from the core.
MemWrite  input  1  store enable; write is committed on the next rising clk.
ReadData  output  32  load data to the core; combinational from DataAdr.
gpio_out  output  32  GPIO output register value.
timer_irq  output  1  level interrupt = TMR_STAT.match AND TMR_CTRL.irq_en.

Behaviour:
- Addressing: word-aligned; DataAdr[1:0] ignored for every access.
- RAM select: DataAdr < DEPTH*4. Index = DataAdr[log2(DEPTH)+1:2].
- MMIO select: DataAdr[31:12] == MMIO_BASE[31:12]. Offset = DataAdr[11:0].
- Any other address: reads return 0 and writes are ignored.
- Reads: fully combinational with zero latency, as the single-cycle core requires. They return register/RAM contents as they stood before the current edge.
- RAM writes: synchronous. On the rising clk with MemWrite=1 and RAM selected, RAM[index] <= WriteData.
- RAM is not cleared by reset; contents are undefined after power-up.
- MMIO register map (offset, name, access):
  - 0x00 GPIO_OUT, RW, 32 bits.
  - 0x04 TMR_CTRL, RW: bit0 en, bit1 auto_reload, bit2 irq_en. Bits 31:3 read as 0.
  - 0x08 TMR_COUNT, RW, 32 bits.
  - 0x0C TMR_CMP, RW, 32 bits.
  - 0x10 TMR_STAT: bit0 match, W1C. Writing 1 to bit0 clears it; writing 0 has no effect. Other bits read as 0.
  - Offsets not in this map: read 0, writes ignored.
- Reset (rst low, asynchronous): GPIO_OUT=0, TMR_CTRL=0, TMR_COUNT=0, TMR_CMP=32'hFFFF_FFFF, match=0. Therefore gpio_out=0 and timer_irq=0.
- Reset asserted mid-count: all timer state returns to reset values immediately, with no clock required.
- Timer, each rising clk (uses the TMR_CTRL value held before the edge):
  - en=0: COUNT holds.
  - en=1 and COUNT==CMP: match <= 1. COUNT <= 0 if auto_reload=1, else COUNT+1.
  - en=1 and COUNT!=CMP: COUNT <= COUNT+1.
  - Increment wraps modulo 2^32 (FFFF_FFFF -> 0); no flag is raised on wrap.
- Precedence on simultaneous events:
  - A CPU write to TMR_COUNT on the same edge overrides both increment and reload. The compare in that cycle still uses the old COUNT.
  - A new match set on the same edge as a W1C write of match: set wins, so match stays 1.
  - A write to TMR_CTRL takes effect from the following edge.
  - A write to TMR_CMP takes effect for the compare on the following edge.
- timer_irq is combinational from registered state. It asserts in the cycle after the match edge and stays high until cleared or irq_en=0.

Test Plan:
1. RAM write/read: MemWrite=1, DataAdr=0x0000_0010, WriteData=0xDEAD_BEEF, one edge. Then read DataAdr=0x0000_0013 -> ReadData=0xDEAD_BEEF. Read DataAdr=0x0000_0800 (unmapped) -> 0.
2. GPIO: write 0xA5A5_0001 to 0x0000_1000 -> gpio_out=0xA5A5_0001 after the edge. Assert rst low mid-cycle -> gpio_out=0 immediately, with no clock edge.
3. Auto-reload: CMP=3, CTRL=0x7 -> COUNT sequence 0,1,2,3,0,1. match=1 and timer_irq=1 from the edge after COUNT==3. Write 1 to 0x1010 -> match=0 and irq drops, until the next wrap at 3.
4. Free-run wrap: CTRL=0x1, write COUNT=0xFFFF_FFFE, CMP=5 -> COUNT reads FFFF_FFFF then 0000_0000. No match until COUNT==5.
5. Collisions:
   - Write COUNT=100 on the edge where COUNT==CMP with auto_reload=1 -> COUNT=100 and match=1.
   - Write W1C on the edge where a match occurs -> match remains 1.
6. Reset values and masking: after rst, read 0x1004=0, 0x100C=0xFFFF_FFFF, 0x1010=0. Write 0xFFFF_FFFF to CTRL -> reads back 0x7.
